// File: rtl/cart_bridge_pkg.sv
// Shared types for the cartridge/ROM download bridge to SDRAM port 1.
// Build option: CART_CHECKSUM_EN adds the dl_sum download checksum output.
package cart_bridge_pkg;

  localparam int CART_ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } state_t;

  typedef struct packed {
    logic [CART_ADDR_W-1:0] addr;
    logic [7:0]             data;
  } fifo_entry_t;

  // System ROM images alias into an 8 KiB window at sys_base; cart images map 1:1.
  function automatic logic [CART_ADDR_W-1:0] map_addr(
    input logic                   sel_cart,
    input logic [CART_ADDR_W-1:0] a,
    input logic [CART_ADDR_W-1:0] sys_base
  );
    return sel_cart ? a : (sys_base | {2'b00, a[12:0]});
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small show-ahead synchronous FIFO; head entry is visible combinationally on dout.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module byte_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_sys,
  input  logic res_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty,
  output logic drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T             mem_reg [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (push_ok)
      mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cart_sdram_bridge.sv
// Download write-buffer plus one-word cart read cache in front of SDRAM port 1.
// Build option: define CART_CHECKSUM_EN to add the dl_sum checksum output.
module cart_sdram_bridge
  import cart_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [14:0] SYS_BASE   = 15'h6000
) (
  input  logic        clk_sys,
  input  logic        res_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        cart_rd,
  input  logic [15:0] cart_addr,
  output logic [7:0]  cart_do,
  output logic        cart_valid,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic [23:0] sdram_a,
  output logic        sdram_we,
  output logic [1:0]  sdram_ds,
  output logic [15:0] sdram_d,
  input  logic [15:0] sdram_q,
  output logic        dl_done,
  output logic        ovf
`ifdef CART_CHECKSUM_EN
  ,
  output logic [15:0] dl_sum
`endif
);

  state_t      state_reg;
  logic        download_d_reg;
  logic        dl_fell_reg;
  logic [13:0] tag_reg;
  logic [15:0] word_reg;
  logic        valid_reg;
  logic        stale_reg;

  fifo_entry_t push_entry;
  fifo_entry_t head_entry;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_drop;
  logic        dl_rise;
  logic        dl_fall;
  logic        in_range;
  logic        hit;
  logic        unused_bits;

  assign unused_bits = ^{ioctl_index[7:1], cart_addr[15], fifo_full};

  assign dl_rise  = ioctl_download & ~download_d_reg;
  assign dl_fall  = ~ioctl_download & download_d_reg;
  assign in_range = (ioctl_addr[24:15] == 10'd0);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = map_addr(ioctl_index[0], ioctl_addr[14:0], SYS_BASE);
    push_entry.data = ioctl_dout;
  end

  assign fifo_push = ioctl_wr && in_range;
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fifo_entry_t)
  ) u_fifo (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .push    (fifo_push),
    .din     (push_entry),
    .pop     (fifo_pop),
    .dout    (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign hit        = valid_reg && (tag_reg == cart_addr[14:1]);
  assign cart_valid = hit;
  assign cart_do    = !hit ? 8'hFF : (cart_addr[0] ? word_reg[15:8] : word_reg[7:0]);

  // Built only from registers, so the pulse is clean and zero out of reset.
  assign dl_done = dl_fell_reg && fifo_empty && (state_reg == IDLE);

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      download_d_reg <= 1'b0;
      dl_fell_reg    <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      download_d_reg <= ioctl_download;
      if (dl_rise)
        dl_fell_reg <= 1'b0;
      else if (dl_fall)
        dl_fell_reg <= 1'b1;
      else if (dl_done)
        dl_fell_reg <= 1'b0;
      if (dl_rise)
        ovf <= fifo_drop;
      else if (fifo_drop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_reg <= IDLE;
      sdram_req <= 1'b0;
      sdram_we  <= 1'b0;
      sdram_a   <= '0;
      sdram_ds  <= '0;
      sdram_d   <= '0;
      tag_reg   <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
      stale_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            sdram_a   <= {9'b0, head_entry.addr[14:1]};
            sdram_ds  <= {head_entry.addr[0], ~head_entry.addr[0]};
            sdram_d   <= {head_entry.data, head_entry.data};
            sdram_we  <= 1'b1;
            sdram_req <= ~sdram_req;
            state_reg <= WR_WAIT;
          end else if (!ioctl_download && cart_rd && !hit) begin
            sdram_a   <= {9'b0, cart_addr[14:1]};
            sdram_ds  <= 2'b11;
            sdram_we  <= 1'b0;
            sdram_req <= ~sdram_req;
            tag_reg   <= cart_addr[14:1];
            stale_reg <= 1'b0;
            state_reg <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (sdram_ack == sdram_req)
            state_reg <= IDLE;
        end
        RD_WAIT: begin
          if (sdram_ack == sdram_req) begin
            word_reg  <= sdram_q;
            valid_reg <= ~stale_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // A download start may overwrite the cached word, including a fill still in flight.
      if (dl_rise) begin
        valid_reg <= 1'b0;
        stale_reg <= 1'b1;
      end
    end
  end

`ifdef CART_CHECKSUM_EN
  logic [15:0] sum_reg;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n)
      sum_reg <= '0;
    else if (dl_rise)
      sum_reg <= '0;
    else if (fifo_pop)
      sum_reg <= sum_reg + {8'h00, head_entry.data};
  end

  assign dl_sum = sum_reg;
`endif

endmodule

// File: tb/tb_cart_sdram_bridge.sv
// Directed bench for cart_sdram_bridge with a toggle-handshake SDRAM responder.
module tb_cart_sdram_bridge;

  logic        clk_sys = 1'b0;
  logic        res_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        cart_rd = 1'b0;
  logic [15:0] cart_addr = 16'h0000;
  logic        sdram_ack = 1'b0;
  logic [15:0] sdram_q = 16'h0000;
  wire  [7:0]  cart_do;
  wire         cart_valid;
  wire         sdram_req;
  wire  [23:0] sdram_a;
  wire         sdram_we;
  wire  [1:0]  sdram_ds;
  wire  [15:0] sdram_d;
  wire         dl_done;
  wire         ovf;
`ifdef CART_CHECKSUM_EN
  wire  [15:0] dl_sum;
`endif

  cart_sdram_bridge #(
    .FIFO_DEPTH (4),
    .SYS_BASE   (15'h6000)
  ) dut (
    .clk_sys        (clk_sys),
    .res_n          (res_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .cart_rd        (cart_rd),
    .cart_addr      (cart_addr),
    .cart_do        (cart_do),
    .cart_valid     (cart_valid),
    .sdram_req      (sdram_req),
    .sdram_ack      (sdram_ack),
    .sdram_a        (sdram_a),
    .sdram_we       (sdram_we),
    .sdram_ds       (sdram_ds),
    .sdram_d        (sdram_d),
    .sdram_q        (sdram_q),
    .dl_done        (dl_done),
    .ovf            (ovf)
`ifdef CART_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          ack_delay = 3;
  int          pend_cnt = 0;
  int          req_cycle = 0;
  int          ack_cycle = 0;
  int          dl_cnt = 0;
  int          dl_cycle = 0;
  logic [15:0] rd_data = 16'h1234;
  logic [23:0] log_a [16];
  logic        log_we [16];
  logic [1:0]  log_ds [16];
  logic [15:0] log_d [16];
  int          log_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // SDRAM responder: logs each request, acks ack_delay cycles after first seeing it.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      cyc++;
      if (!res_n) begin
        sdram_ack = 1'b0;
        pend_cnt  = 0;
      end else if (sdram_req != sdram_ack) begin
        if (pend_cnt == 0) begin
          req_cycle = cyc;
          if (log_n < 16) begin
            log_a[log_n]  = sdram_a;
            log_we[log_n] = sdram_we;
            log_ds[log_n] = sdram_ds;
            log_d[log_n]  = sdram_d;
          end
          log_n++;
          $display("[%0d] sdram %s a=%h ds=%b d=%h", cyc, sdram_we ? "wr" : "rd",
                   sdram_a, sdram_ds, sdram_d);
        end
        if (pend_cnt >= ack_delay) begin
          if (!sdram_we)
            sdram_q = rd_data;
          sdram_ack = sdram_req;
          ack_cycle = cyc;
          pend_cnt  = 0;
        end else begin
          pend_cnt++;
        end
      end
      if (dl_done) begin
        dl_cnt++;
        dl_cycle = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max, output int at);
    bit seen;
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (cart_valid) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    if (!seen)
      check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_a [4];
    logic [1:0]  exp_ds [4];
    logic [15:0] exp_d [4];
    int          start;
    int          valid_at;
    bit          seen;

    exp_a  = '{24'h0, 24'h0, 24'h1, 24'h1};
    exp_ds = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_d  = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    // Reset state
    ticks(3);
    check("rst_req", sdram_req, 1'b0);
    check("rst_we", sdram_we, 1'b0);
    check("rst_a", sdram_a, 24'h0);
    check("rst_ds", sdram_ds, 2'b00);
    check("rst_d", sdram_d, 16'h0);
    check("rst_dl_done", dl_done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_cart_valid", cart_valid, 1'b0);
    check("rst_cart_do", cart_do, 8'hFF);
    res_n = 1'b1;
    tick();

    // Cart download of four bytes
    log_n = 0;
    dl_cnt = 0;
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h0, 8'hAA);
    wr_byte(25'h1, 8'hBB);
    wr_byte(25'h2, 8'hCC);
    wr_byte(25'h3, 8'hDD);
    ioctl_download = 1'b0;
    ticks(40);
    check("cart_dl_count", log_n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cart_dl_a%0d", i), log_a[i], exp_a[i]);
      check($sformatf("cart_dl_ds%0d", i), log_ds[i], exp_ds[i]);
      check($sformatf("cart_dl_d%0d", i), log_d[i], exp_d[i]);
      check($sformatf("cart_dl_we%0d", i), log_we[i], 1'b1);
    end
    check("cart_dl_done_once", dl_cnt, 1);
    check("cart_dl_done_after_ack", dl_cycle - ack_cycle, 1);
`ifdef CART_CHECKSUM_EN
    check("cart_dl_sum", dl_sum, 16'h030E);
`endif

    // System ROM download plus an out-of-range byte
    log_n = 0;
    dl_cnt = 0;
    ioctl_index = 8'h00;
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h0005, 8'h5A);
    wr_byte(25'h0008000, 8'h77);
    ioctl_download = 1'b0;
    ticks(20);
    check("sys_count", log_n, 1);
    check("sys_a", log_a[0], 24'h3002);
    check("sys_ds", log_ds[0], 2'b10);
    check("sys_d", log_d[0], 16'h5A5A);
    check("sys_ignored_no_ovf", ovf, 1'b0);
    check("sys_dl_done", dl_cnt, 1);

    // Overflow with a stalled SDRAM
    ack_delay = 50;
    log_n = 0;
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++)
      wr_byte(25'h10 + 25'(i), 8'h60 + 8'(i));
    check("ovf_set", ovf, 1'b1);
    ioctl_download = 1'b0;
    ticks(320);
    check("ovf_written", log_n, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("ovf_a%0d", i), log_a[i], 24'((16 + i) >> 1));
      check($sformatf("ovf_d%0d", i), log_d[i], {8'h60 + 8'(i), 8'h60 + 8'(i)});
    end
    check("ovf_sticky", ovf, 1'b1);
    ioctl_download = 1'b1;
    tick();
    check("ovf_cleared", ovf, 1'b0);
    ioctl_download = 1'b0;
    ack_delay = 3;
    ticks(5);

    // Cart read miss then hit on the other byte of the word
    rd_data = 16'h1234;
    log_n = 0;
    cart_addr = 16'h0010;
    start = cyc;
    cart_rd = 1'b1;
    check("rd_miss_valid", cart_valid, 1'b0);
    check("rd_miss_do", cart_do, 8'hFF);
    wait_valid("rd_fill_timeout", 20, valid_at);
    check("rd_req_latency", req_cycle - start, 1);
    check("rd_valid_latency", valid_at - ack_cycle, 1);
    check("rd_do_lo", cart_do, 8'h34);
    check("rd_a", log_a[0], 24'h8);
    check("rd_ds", log_ds[0], 2'b11);
    check("rd_we", log_we[0], 1'b0);
    cart_addr = 16'h0011;
    #1;
    check("rd_hit_valid", cart_valid, 1'b1);
    check("rd_do_hi", cart_do, 8'h12);
    ticks(10);
    check("rd_single_req", log_n, 1);

    // Writes during a pending cart miss go first; the read waits for the drain
    rd_data = 16'h5678;
    log_n = 0;
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    cart_addr = 16'h0020;
    tick();
    wr_byte(25'h100, 8'h11);
    wr_byte(25'h101, 8'h22);
    ticks(20);
    check("mix_no_read_in_dl", log_n, 2);
    ioctl_download = 1'b0;
    wait_valid("mix_fill_timeout", 60, valid_at);
    check("mix_count", log_n, 3);
    check("mix_w0", log_we[0], 1'b1);
    check("mix_w0_a", log_a[0], 24'h80);
    check("mix_w1", log_we[1], 1'b1);
    check("mix_rd", log_we[2], 1'b0);
    check("mix_rd_a", log_a[2], 24'h10);
    check("mix_do", cart_do, 8'h78);
    cart_rd = 1'b0;
    ticks(5);

    // Asynchronous reset in the middle of a write
    ack_delay = 20;
    log_n = 0;
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h2, 8'h99);
    ticks(3);
    check("mid_wr_we", sdram_we, 1'b1);
    check("mid_wr_pending", sdram_req != sdram_ack, 1'b1);
    res_n = 1'b0;
    #1;
    check("arst_req", sdram_req, 1'b0);
    check("arst_we", sdram_we, 1'b0);
    check("arst_a", sdram_a, 24'h0);
    check("arst_ds", sdram_ds, 2'b00);
    check("arst_d", sdram_d, 16'h0);
    ticks(2);
    ack_delay = 3;
    res_n = 1'b1;
    tick();
    log_n = 0;
    wr_byte(25'h3, 8'h42);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (log_n > 0)
        seen = 1'b1;
    end
    if (!seen)
      check("post_rst_timeout", 32'd0, 32'd1);
    check("post_rst_req", sdram_req, 1'b1);
    check("post_rst_a", log_a[0], 24'h1);
    check("post_rst_ds", log_ds[0], 2'b10);
    check("post_rst_d", log_d[0], 16'h4242);
    ioctl_download = 1'b0;
    ticks(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
